multiplier_radix2_mult_pipe: RTL
================================

# multiplier_radix2_mult_pipe

Pipelined, parametrised radix-2 array multiplier with val/rdy handshaking and a per-transaction signed/unsigned mode. It is the successor to the combinational square Baugh-Wooley array. The array rows are split into `NUM_STAGES` register-separated groups, which gives one product per cycle at full throughput. It sits in the multiplier library and feeds the gradient/product datapaths of the optical-flow pipeline through standard latency-insensitive interfaces.

## Interface
- `X_WIDTH`, default 8: multiplier operand `x` width; must be ≥2.
- `Y_WIDTH`, default 8: multiplicand operand `y` width; must be ≥2.
- `P_WIDTH`, default `X_WIDTH+Y_WIDTH`: product width; fixed, not to be overridden.
- `NUM_STAGES`, default 2: pipeline register stages, legal range 1..`X_WIDTH+1`.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_val` in 1: request valid.
- `req_rdy` out 1: request ready.
- `req_x` in `X_WIDTH`: operand x.
- `req_y` in `Y_WIDTH`: operand y.
- `req_signed` in 1: 1 selects two's-complement operands, 0 selects unsigned.
- `req_acc` in 1: accumulate request; present only with `MULT_ACC_EN`.
- `resp_val` out 1: response valid.
- `resp_rdy` in 1: response ready.
- `resp_p` out `P_WIDTH`: product, or accumulated result.

## Operation
- **Array structure:**
  - The array has `X_WIDTH+1` rows: `X_WIDTH` partial-product rows plus the final ripple row.
  - Rows are assigned to stages in order, `ceil((X_WIDTH+1)/NUM_STAGES)` rows per stage; the last stage may hold fewer.
  - Between stages, registers hold: the running sum vector, the carry vector, the emitted low product bits, the unconsumed `x` bits, `y`, the mode bit and the valid bit (plus the acc bit when enabled).
- **Signed mode (Baugh-Wooley):**
  - Cells in the last partial-product column and the last partial-product row use complemented partial products, except the corner cell, which does not.
  - A constant 1 is injected at row 1's top-column sum input.
  - A constant 1 is injected at the final row's MSB `a` input.
- **Unsigned mode:**
  - All cells use plain AND partial products.
  - Both constant-1 injections are forced to 0.
- **Result:** exact in both modes; `resp_p` equals the full product modulo 2^`P_WIDTH`, with no truncation.
- **Stage advance:** stage i advances when its next stage is empty or is itself advancing. The last stage advances when `resp_rdy` is 1.
- **Ready:** `req_rdy` = NOT(stage0 valid) OR stage0 advancing. It is combinational from `resp_rdy`.
- **Accept:** a request is accepted on a cycle with `req_val && req_rdy`.
- **Response:** `resp_val` is the last stage's valid bit. `resp_p` is held stable while `resp_val && !resp_rdy`.
- **Ordering:** responses are strictly in request order; no drops and no duplicates.
- **Bubbles:** bubbles collapse; an empty stage never blocks an upstream stage.

## Timing
- **Latency:** exactly `NUM_STAGES` cycles from request acceptance to `resp_val`, when unstalled.
- **Throughput:** one transaction per cycle while `resp_rdy` is held high.
- **Capacity:** at most `NUM_STAGES` transactions in flight.
- **Full pipeline:** when all stages are full and `resp_rdy` is 0, `req_rdy` is 0 in the same cycle.
- **Simultaneous accept and drain:** a new request is accepted in the same cycle the last stage drains, without a bubble.
- **Reset values:**
  - All stage valid bits 0 and `resp_val` 0.
  - `resp_p` 0 and all datapath registers 0.
  - Accumulator 0.
  - `req_rdy` is 1 (pipeline empty).
- **Reset mid-operation:** all in-flight transactions are discarded immediately (asynchronous). No response appears for them after reset is released.
- **Response-side rule:** `resp_val` never drops without a handshake.

## Configuration
- **`MULT_ACC_EN` defined:**
  - Adds the `req_acc` port and a `P_WIDTH` accumulator register updated at the last stage.
  - When a transaction with acc=1 drains: result = product + accumulator, wrapping modulo 2^`P_WIDTH`. With acc=0: result = product.
  - On every handshake, the accumulator is loaded with the returned result.
  - A stalled transaction does not update the accumulator until its handshake.
- **`MULT_ACC_EN` not defined:** no `req_acc` port and no accumulator; `resp_p` is always the plain product.

## Test plan
- **Basic products** (X=Y=4, `NUM_STAGES`=2, `resp_rdy`=1):
  - signed x=-8, y=-8 -> `resp_p`=0x40 two cycles after acceptance;
  - signed x=-1, y=7 -> 0xF9;
  - unsigned x=15, y=15 -> 0xE1.
- **Streaming:** 16 back-to-back random signed/unsigned requests -> 16 in-order correct responses; `resp_val` is high every cycle from cycle 2 to cycle 17.
- **Backpressure:** hold `resp_rdy`=0 and issue 3 requests -> `req_rdy` falls after 2 accepted and `resp_p` stays stable. Release `resp_rdy` -> a third request is accepted in the same cycle the first response drains.
- **Reset mid-flight:** assert `reset` low for one cycle with 2 transactions in flight -> `resp_val`=0 and `req_rdy`=1 immediately; no stale responses afterwards.
- **Accumulate** (with `MULT_ACC_EN`): unsigned 3×4 with acc=0 -> 12; then 2×5 with acc=1 -> 22; then 15×15 with acc=1 -> 247 (0xF7).
- **Extreme configurations:** `NUM_STAGES`=1 and `NUM_STAGES`=`X_WIDTH+1` at X=Y=8, exhaustive signed and unsigned operands -> all results match the reference product, with latencies of 1 and 9 respectively.

Source files
------------

// File: rtl/multiplier_radix2_mult_pipe.sv
// multiplier_radix2_mult_pipe: pipelined radix-2 Baugh-Wooley array multiplier with val/rdy handshaking.
// Optional feature: define MULT_ACC_EN to add the req_acc port and a result accumulator.
module multiplier_radix2_mult_pipe #(
    parameter  int X_WIDTH    = 8,
    parameter  int Y_WIDTH    = 8,
    parameter  int NUM_STAGES = 2,
    localparam int P_WIDTH    = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [X_WIDTH-1:0] req_x,
    input  logic [Y_WIDTH-1:0] req_y,
    input  logic               req_signed,
`ifdef MULT_ACC_EN
    input  logic               req_acc,
`endif
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [P_WIDTH-1:0] resp_p
);
    localparam int ROWS = X_WIDTH + 1;
    localparam int RPS  = (ROWS + NUM_STAGES - 1) / NUM_STAGES;
    // Baugh-Wooley correction terms for the complemented last row/column; with square operands the
    // first two fold into the row-1 top-column 1 and the last one is the final-row MSB 1.
    localparam logic [P_WIDTH-1:0] BW_CONST = (P_WIDTH'(1) << (X_WIDTH - 1))
                                            + (P_WIDTH'(1) << (Y_WIDTH - 1))
                                            + (P_WIDTH'(1) << (P_WIDTH - 1));

    typedef struct packed {
        logic               val;
        logic               sg;
        logic               acc;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic [P_WIDTH-1:0] s;
        logic [P_WIDTH-1:0] c;
    } stage_t;

    stage_t                r_stg [NUM_STAGES];
    stage_t                w_src [NUM_STAGES+1];
    stage_t                w_nxt [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_en;
    logic                  w_unused;

    // Apply the array rows owned by stage g: carry-save partial-product rows, then the final ripple row.
    function automatic stage_t advance(input stage_t d, input int g);
        stage_t             o;
        logic [P_WIDTH-1:0] pp;
        o = d;
        for (int r = 0; r < ROWS; r++) begin
            if (r >= g * RPS && r < (g + 1) * RPS) begin
                if (r < X_WIDTH) begin
                    pp = '0;
                    for (int k = 0; k < Y_WIDTH; k++)
                        pp[r+k] = (o.x[r] & o.y[k]) ^ (o.sg && ((k == Y_WIDTH - 1) != (r == X_WIDTH - 1)));
                    {o.s, o.c} = {o.s ^ o.c ^ pp, ((o.s & o.c) | (o.s & pp) | (o.c & pp)) << 1};
                end else begin
                    o.s = o.s + o.c;
                    o.c = '0;
                end
            end
        end
        return o;
    endfunction

    // Stage inputs: the request enters stage 0, each later stage is fed by its predecessor's register.
    always_comb begin
        w_src[0]     = '0;
        w_src[0].val = req_val;
        w_src[0].sg  = req_signed;
`ifdef MULT_ACC_EN
        w_src[0].acc = req_acc;
`endif
        w_src[0].x   = req_x;
        w_src[0].y   = req_y;
        w_src[0].s   = req_signed ? BW_CONST : '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_nxt[i]   = advance(w_src[i], i);
            w_src[i+1] = r_stg[i];
        end
    end

    // A stage may load when it is empty or its contents move on; empty stages never block upstream.
    always_comb begin
        w_en[NUM_STAGES-1] = !r_stg[NUM_STAGES-1].val || resp_rdy;
        for (int i = NUM_STAGES - 2; i >= 0; i--)
            w_en[i] = !r_stg[i].val || w_en[i+1];
    end

    // Stage registers; asynchronous reset discards every in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++)
                r_stg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++)
                if (w_en[i]) r_stg[i] <= w_nxt[i];
        end
    end

    assign req_rdy  = w_en[0];
    assign resp_val = r_stg[NUM_STAGES-1].val;
    assign w_unused = ^w_src[NUM_STAGES];

`ifdef MULT_ACC_EN
    logic [P_WIDTH-1:0] r_accum;

    assign resp_p = r_stg[NUM_STAGES-1].acc ? r_stg[NUM_STAGES-1].s + r_accum : r_stg[NUM_STAGES-1].s;

    // Accumulator captures each result only when it is handed off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_accum <= '0;
        else if (resp_val && resp_rdy) r_accum <= resp_p;
    end
`else
    assign resp_p = r_stg[NUM_STAGES-1].s;
`endif
endmodule
